text_dump_tx: RTL and testbench

TEXT_DUMP_TX -- requirements
Module: text_dump_tx

---
 rtl/text_dump_tx.sv | 182 ++++++++++++++++++
 tb/tb_text_dump_tx.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_dump_tx.sv
// Text RAM dump over UART 8N1: walks ROWS x COLS characters row by row and
// terminates each row with CR/LF. Zero bytes in the RAM go out as spaces.
module text_dump_tx #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int COLS         = 32,
  parameter int ROWS         = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [1:0] rd_row,
  output logic [4:0] rd_col,
  input  logic [7:0] rd_data,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [4:0]        COL_LAST  = 5'(COLS - 1);
  localparam logic [1:0]        ROW_LAST  = 2'(ROWS - 1);

  typedef enum logic [3:0] {
    IDLE, FETCH, LATCH, START, DATA, STOP, EOL_CR, EOL_LF, DONE
  } state_t;

  typedef enum logic [1:0] {
    KIND_CHAR, KIND_CR, KIND_LF
  } kind_t;

  state_t            state_q, state_d;
  kind_t             kind_q, kind_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic [1:0]        row_q, row_d;
  logic [4:0]        col_q, col_d;
  logic              tx_q, tx_d;
  logic              bit_end;

  assign bit_end = (baud_q == BAUD_LAST);

  // NOTE: every variable gets its default first, so no branch of the case
  // below leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    row_d   = row_q;
    col_d   = col_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          row_d   = '0;
          col_d   = '0;
          baud_d  = '0;
          bit_d   = '0;
        end
      end

      FETCH: state_d = LATCH;

      LATCH: begin
        shift_d = (rd_data == 8'h00) ? 8'h20 : rd_data;
        kind_d  = KIND_CHAR;
        baud_d  = '0;
        state_d = START;
      end

      // EOL states double as the start bit of the CR/LF frames, so line
      // endings follow the previous stop bit with no idle gap.
      START, EOL_CR, EOL_LF: begin
        if (bit_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      DATA: begin
        if (bit_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      STOP: begin
        if (bit_end) begin
          baud_d = '0;
          unique case (kind_q)
            KIND_CHAR: begin
              if (col_q != COL_LAST) begin
                col_d   = col_q + 5'd1;
                state_d = FETCH;
              end else begin
                shift_d = 8'h0D;
                kind_d  = KIND_CR;
                state_d = EOL_CR;
              end
            end
            KIND_CR: begin
              shift_d = 8'h0A;
              kind_d  = KIND_LF;
              state_d = EOL_LF;
            end
            default: begin
              if (row_q != ROW_LAST) begin
                row_d   = row_q + 2'd1;
                col_d   = '0;
                state_d = FETCH;
              end else begin
                state_d = DONE;
              end
            end
          endcase
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
        row_d   = '0;
        col_d   = '0;
      end

      default: state_d = IDLE;
    endcase
  end

  // tx is computed from the next state so the registered line lines up
  // exactly with the state that owns each bit period.
  always_comb begin
    unique case (state_d)
      START, EOL_CR, EOL_LF: tx_d = 1'b0;
      DATA:                  tx_d = shift_d[0];
      default:               tx_d = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the values present before the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      kind_q  <= KIND_CHAR;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      row_q   <= '0;
      col_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      row_q   <= row_d;
      col_q   <= col_d;
      tx_q    <= tx_d;
    end
  end

  assign rd_row = row_q;
  assign rd_col = col_q;
  assign tx     = tx_q;
  assign busy   = (state_q != IDLE) && (state_q != DONE);
  assign done   = (state_q == DONE);

endmodule

// File: tb/tb_text_dump_tx.sv
// Self-checking bench for text_dump_tx: a UART decoder rebuilds the byte
// stream and compares it against the dump order computed from the RAM image.
module tb_text_dump_tx;

  localparam int CPB    = 4;
  localparam int COLS   = 32;
  localparam int ROWS   = 4;
  localparam int NBYTES = ROWS * (COLS + 2);
  localparam int FRAME  = 10 * CPB;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [1:0] rd_row;
  logic [4:0] rd_col;
  logic [7:0] rd_data;
  logic       tx, busy, done;

  logic [7:0] mem [ROWS][COLS];

  int errors = 0;
  int checks = 0;

  logic [7:0] frames[$];
  int         starts[$];
  int         stop_bad = 0;
  int         done_cnt = 0;
  int         done_cyc = 0;
  int         cyc      = 0;
  logic       busy_at_done     = 1'b0;
  logic       busy_before_done = 1'b0;

  text_dump_tx #(
    .CLKS_PER_BIT(CPB),
    .COLS        (COLS),
    .ROWS        (ROWS)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .rd_row (rd_row),
    .rd_col (rd_col),
    .rd_data(rd_data),
    .tx     (tx),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  // Synchronous text RAM: data valid one clock after the address.
  always @(posedge clk) rd_data <= mem[rd_row][rd_col];

  // UART receiver and done/busy observer, sampling on the falling edge.
  initial begin : monitor
    int         cnt;
    int         k0;
    logic [7:0] sh;
    logic       busy_prev;
    cnt = -1;
    k0 = 0;
    sh = 8'h00;
    busy_prev = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        cnt = -1;
      end else if (cnt < 0) begin
        if (tx === 1'b0) begin
          cnt = 0;
          k0  = cyc;
          sh  = 8'h00;
        end
      end else begin
        cnt++;
        if (cnt == 2 && tx !== 1'b0) begin
          stop_bad++;
          cnt = -1;
        end else if (cnt >= 6 && cnt <= 34 && ((cnt - 6) % CPB) == 0) begin
          sh[(cnt - 6) / CPB] = tx;
        end else if (cnt == 38) begin
          if (tx !== 1'b1) stop_bad++;
          frames.push_back(sh);
          starts.push_back(k0);
          cnt = -1;
        end
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc         = cyc;
        busy_at_done     = busy;
        busy_before_done = busy_prev;
      end
      busy_prev = busy;
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // Byte k of a complete dump, straight from the dump-order rules.
  function automatic logic [7:0] exp_byte(input int k);
    int row, pos;
    row = k / (COLS + 2);
    pos = k % (COLS + 2);
    if (pos < COLS) return (mem[row][pos] == 8'h00) ? 8'h20 : mem[row][pos];
    else if (pos == COLS) return 8'h0D;
    else return 8'h0A;
  endfunction

  task automatic fill_random();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        mem[r][c] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
  endtask

  task automatic clear_mon();
    frames.delete();
    starts.delete();
    stop_bad = 0;
    done_cnt = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int base, input int budget, input string name);
    int n;
    n = 0;
    while (done_cnt == base && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done_cnt == base) begin
      errors++;
      $display("FAIL %s done_timeout: no done within %0d cycles, expected one", name, budget);
    end
  endtask

  task automatic check_dump(input string name);
    int n, gap, egap;
    checks++;
    if (frames.size() != NBYTES) begin
      errors++;
      $display("FAIL %s frame_count: got %0d expected %0d", name, frames.size(), NBYTES);
    end
    n = (frames.size() < NBYTES) ? frames.size() : NBYTES;
    for (int k = 0; k < n; k++) begin
      checks++;
      if (frames[k] !== exp_byte(k)) begin
        errors++;
        $display("FAIL %s byte[%0d]: got %02h expected %02h", name, k, frames[k], exp_byte(k));
      end
    end
    for (int k = 1; k < n; k++) begin
      gap  = starts[k] - starts[k-1];
      egap = ((k % (COLS + 2)) < COLS) ? FRAME + 2 : FRAME;
      checks++;
      if (gap !== egap) begin
        errors++;
        $display("FAIL %s spacing[%0d]: got %0d cycles expected %0d", name, k, gap, egap);
      end
    end
    checks++;
    if (stop_bad != 0) begin
      errors++;
      $display("FAIL %s framing: got %0d bad start/stop bits expected 0", name, stop_bad);
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    #2;
    checks += 5;
    if (tx !== 1'b1)     begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
    if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    if (done !== 1'b0)   begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    if (rd_row !== 2'd0) begin errors++; $display("FAIL reset_row: got %0d expected 0", rd_row); end
    if (rd_col !== 5'd0) begin errors++; $display("FAIL reset_col: got %0d expected 0", rd_col); end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_fill();
    logic [9:0] wave;
    logic [9:0] bad;
    int         n;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        mem[r][c] = 8'h41;
    clear_mon();
    pulse_start();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL fill_busy_rise: got %b expected 1", busy); end
    n = 0;
    while (tx !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    wave = {1'b1, 8'h41, 1'b0};
    bad  = '0;
    for (int i = 0; i < FRAME; i++) begin
      if (i > 0) @(negedge clk);
      if (tx !== wave[i / CPB]) bad[i / CPB] = 1'b1;
    end
    for (int j = 0; j < 10; j++) begin
      checks++;
      if (bad[j]) begin
        errors++;
        $display("FAIL fill_wave bit%0d: line deviated, expected %b for %0d cycles", j, wave[j], CPB);
      end
    end
    wait_done(0, 8000, "fill");
    repeat (20) @(negedge clk);
    check_dump("fill");
    if (frames.size() == NBYTES) begin
      checks += 4;
      if (frames[32] !== 8'h0D)  begin errors++; $display("FAIL fill_frame33: got %02h expected 0d", frames[32]); end
      if (frames[33] !== 8'h0A)  begin errors++; $display("FAIL fill_frame34: got %02h expected 0a", frames[33]); end
      if (frames[135] !== 8'h0A) begin errors++; $display("FAIL fill_frame136: got %02h expected 0a", frames[135]); end
      if (done_cyc !== starts[NBYTES-1] + FRAME) begin
        errors++;
        $display("FAIL fill_done_time: got cycle %0d expected %0d", done_cyc, starts[NBYTES-1] + FRAME);
      end
    end
    checks += 4;
    if (done_cnt !== 1)            begin errors++; $display("FAIL fill_done_count: got %0d expected 1", done_cnt); end
    if (busy_at_done !== 1'b0)     begin errors++; $display("FAIL fill_busy_at_done: got %b expected 0", busy_at_done); end
    if (busy_before_done !== 1'b1) begin errors++; $display("FAIL fill_busy_before_done: got %b expected 1", busy_before_done); end
    if (busy !== 1'b0)             begin errors++; $display("FAIL fill_busy_idle: got %b expected 0", busy); end
  endtask

  task automatic test_zero_tilde();
    fill_random();
    mem[0][0]  = 8'h00;
    mem[3][31] = 8'h7E;
    clear_mon();
    pulse_start();
    wait_done(0, 8000, "zero");
    repeat (20) @(negedge clk);
    check_dump("zero");
    if (frames.size() == NBYTES) begin
      checks += 2;
      if (frames[0] !== 8'h20)   begin errors++; $display("FAIL zero_first: got %02h expected 20", frames[0]); end
      if (frames[133] !== 8'h7E) begin errors++; $display("FAIL zero_frame134: got %02h expected 7e", frames[133]); end
    end
  endtask

  task automatic test_start_held();
    fill_random();
    clear_mon();
    @(negedge clk);
    start = 1'b1;
    repeat (500) @(negedge clk);
    start = 1'b0;
    repeat (1000) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(0, 8000, "held");
    repeat (60) @(negedge clk);
    check_dump("held");
    checks += 2;
    if (done_cnt !== 1) begin errors++; $display("FAIL held_done_count: got %0d expected 1", done_cnt); end
    if (busy !== 1'b0)  begin errors++; $display("FAIL held_restart: busy got %b expected 0", busy); end
  endtask

  task automatic test_reset_mid();
    int n;
    fill_random();
    mem[0][9] = 8'h00;
    clear_mon();
    pulse_start();
    n = 0;
    while (frames.size() < 9 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (tx !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    checks++;
    if (tx !== 1'b0) begin errors++; $display("FAIL mid_pre_reset_tx: got %b expected 0", tx); end
    #1 reset = 1'b0;
    #1;
    checks += 5;
    if (tx !== 1'b1)     begin errors++; $display("FAIL mid_tx: got %b expected 1", tx); end
    if (busy !== 1'b0)   begin errors++; $display("FAIL mid_busy: got %b expected 0", busy); end
    if (done !== 1'b0)   begin errors++; $display("FAIL mid_done: got %b expected 0", done); end
    if (rd_row !== 2'd0) begin errors++; $display("FAIL mid_row: got %0d expected 0", rd_row); end
    if (rd_col !== 5'd0) begin errors++; $display("FAIL mid_col: got %0d expected 0", rd_col); end
    repeat (3) @(negedge clk);
    checks++;
    if (frames.size() !== 9) begin errors++; $display("FAIL mid_frames_before: got %0d expected 9", frames.size()); end
    reset = 1'b1;
    mem[0][0] = 8'($urandom_range(1, 255));
    clear_mon();
    pulse_start();
    wait_done(0, 8000, "restart");
    repeat (20) @(negedge clk);
    check_dump("restart");
  endtask

  task automatic test_done_start();
    int n;
    fill_random();
    clear_mon();
    pulse_start();
    n = 0;
    while (done !== 1'b1 && n < 8000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL ds_done_seen: got %b expected 1", done); end
    start = 1'b1;
    @(negedge clk);
    check_dump("ds_first");
    checks += 2;
    if (busy !== 1'b0) begin errors++; $display("FAIL ds_ignored_in_done: busy got %b expected 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL ds_done_width: got %b expected 0", done); end
    fill_random();
    clear_mon();
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL ds_restart_busy: got %b expected 1", busy); end
    wait_done(0, 8000, "ds_second");
    repeat (20) @(negedge clk);
    check_dump("ds_second");
    checks++;
    if (done_cnt !== 1) begin errors++; $display("FAIL ds_done_count: got %0d expected 1", done_cnt); end
  endtask

  initial begin : main
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        mem[r][c] = 8'h00;
    test_reset();
    test_fill();
    test_zero_tilde();
    test_start_held();
    test_reset_mid();
    test_done_start();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
